// File: rtl/tiger_mem_pkg.sv
// Shared definitions for the Tiger posted-write buffer.
//   - wbuf_state_e : drain/passthrough FSM encodings
//   - wbuf_entry_t : one buffered store {address, data, mem8, mem16}
//   - field widths and offsets of the 66-bit entry, plus a packing helper
package tiger_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } wbuf_state_e;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ENTRY_W   = 66;

    // Bit offsets inside a packed entry (mem16 is the LSB).
    localparam int MEM16_OFS = 0;
    localparam int MEM8_OFS  = 1;
    localparam int DATA_OFS  = 2;
    localparam int ADDR_OFS  = DATA_OFS + DATA_W;

    // Field order matches the offsets above.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              mem8;
        logic              mem16;
    } wbuf_entry_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data,
        input logic              mem8,
        input logic              mem16
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[ADDR_OFS +: ADDR_W] = addr;
        e[DATA_OFS +: DATA_W] = data;
        e[MEM8_OFS]           = mem8;
        e[MEM16_OFS]          = mem16;
        return e;
    endfunction

endpackage

// File: rtl/tiger_avalon_wbuf_if.sv
// Bus bundle around the posted-write buffer.
//   up_*      : processor memory-stage request and stall
//   dn_*      : request towards tiger_avalon and its stall
//   wbuf_*    : buffer status (empty flag, occupancy)
// modport master : processor / downstream side (drives up_* requests, dn_stall)
// modport slave  : the write buffer itself
interface tiger_avalon_wbuf_if #(
    parameter int CNT_W = 3
);
    logic [31:0]      up_memaddress;
    logic             up_memread;
    logic             up_memwrite;
    logic [31:0]      up_memwritedata;
    logic             up_mem8;
    logic             up_mem16;
    logic             up_stall;

    logic [31:0]      dn_memaddress;
    logic             dn_memread;
    logic             dn_memwrite;
    logic [31:0]      dn_memwritedata;
    logic             dn_mem8;
    logic             dn_mem16;
    logic             dn_stall;

    logic             wbuf_empty;
    logic [CNT_W-1:0] wbuf_count;

    modport master (
        output up_memaddress, up_memread, up_memwrite, up_memwritedata,
               up_mem8, up_mem16, dn_stall,
        input  up_stall, dn_memaddress, dn_memread, dn_memwrite,
               dn_memwritedata, dn_mem8, dn_mem16, wbuf_empty, wbuf_count
    );

    modport slave (
        input  up_memaddress, up_memread, up_memwrite, up_memwritedata,
               up_mem8, up_mem16, dn_stall,
        output up_stall, dn_memaddress, dn_memread, dn_memwrite,
               dn_memwritedata, dn_mem8, dn_mem16, wbuf_empty, wbuf_count
    );
endinterface

// File: rtl/tiger_wbuf_fifo.sv
// Synchronous FIFO holding buffered stores.
//   clk, reset : clock, asynchronous active-high reset (clears pointers/count)
//   push_i     : write wdata_i at the tail (ignored when full)
//   pop_i      : drop the head (ignored when empty)
//   head_o     : current head entry, valid while not empty
//   count_o    : occupancy, full_o / empty_o derived from it
module tiger_wbuf_fifo
    import tiger_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only visible through the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tiger_avalon_wbuf.sv
// Posted-write buffer between the Tiger memory stage and tiger_avalon.
// Stores are queued without stalling and drained in order; loads pass
// straight through once no buffered write is left outstanding.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : tiger_avalon_wbuf_if slave (up_*, dn_*, wbuf_empty/count)
module tiger_avalon_wbuf
    import tiger_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    tiger_avalon_wbuf_if.slave  bus
);
    wbuf_state_e        state_q, state_d;
    logic [ENTRY_W-1:0] wdata, head_raw;
    wbuf_entry_t        head;
    logic [CNT_W-1:0]   count;
    logic               full, empty;
    logic               push, pop;
    logic               up_load;

    // A simultaneous read+write is treated as a write only.
    assign up_load = bus.up_memread && !bus.up_memwrite;
    assign push    = bus.up_memwrite && !full;
    assign pop     = (state_q == S_WRITE) && !bus.dn_stall;
    assign wdata   = pack_entry(bus.up_memaddress, bus.up_memwritedata,
                                bus.up_mem8, bus.up_mem16);
    assign head    = head_raw;

    tiger_wbuf_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .head_o  (head_raw),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // Entering S_WRITE on the push itself presents the new entry
                // the cycle after enqueue rather than two cycles later.
                if (!empty || push) begin
                    state_d = S_WRITE;
                end else if (up_load && !bus.dn_stall) begin
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                // Leave only when the last entry pops with nothing arriving.
                if (pop && count == CNT_W'(1) && !push) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (!bus.dn_stall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        logic passthru;
        bus.dn_memaddress   = '0;
        bus.dn_memwritedata = '0;
        bus.dn_mem8         = 1'b0;
        bus.dn_mem16        = 1'b0;
        bus.dn_memread      = 1'b0;
        bus.dn_memwrite     = 1'b0;
        bus.up_stall        = 1'b0;
        passthru = ((state_q == S_IDLE) && empty) || (state_q == S_READ);

        if (!reset) begin
            if (state_q == S_WRITE) begin
                bus.dn_memwrite     = 1'b1;
                bus.dn_memaddress   = head.addr;
                bus.dn_memwritedata = head.data;
                bus.dn_mem8         = head.mem8;
                bus.dn_mem16        = head.mem16;
            end else if (passthru && (up_load || state_q == S_READ)) begin
                bus.dn_memread      = up_load;
                bus.dn_memaddress   = bus.up_memaddress;
                bus.dn_memwritedata = bus.up_memwritedata;
                bus.dn_mem8         = bus.up_mem8;
                bus.dn_mem16        = bus.up_mem16;
            end

            // Full is judged on the registered count only.
            if (bus.up_memwrite) begin
                bus.up_stall = full;
            end else if (bus.up_memread) begin
                bus.up_stall = passthru ? bus.dn_stall : 1'b1;
            end else begin
                bus.up_stall = (state_q == S_READ) ? bus.dn_stall : 1'b0;
            end
        end
    end

    assign bus.wbuf_count = count;
    assign bus.wbuf_empty = empty && (state_q == S_IDLE);

endmodule

// File: doc/tiger_avalon_wbuf.md
# tiger_avalon_wbuf

Posted-write buffer between the Tiger processor memory stage and the `tiger_avalon` access controller. Processor stores to Avalon peripherals are enqueued without stalling and drained in order downstream. Loads pass straight through, but only once every buffered write has been accepted downstream, so program order is preserved.

## Interface

**Parameters**
- `DEPTH`, default 4: buffer entries; power of two, ≥2.
- `CNT_W`, default 3: occupancy counter width, equal to log2(DEPTH)+1.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `up_memaddress`, in, 32: processor byte address.
- `up_memread`, in, 1: processor load request.
- `up_memwrite`, in, 1: processor store request.
- `up_memwritedata`, in, 32: store data, right-aligned.
- `up_mem8`, in, 1: byte access.
- `up_mem16`, in, 1: halfword access.
- `up_stall`, out, 1: processor must hold its request.
- `dn_memaddress`, out, 32: to `tiger_avalon` memaddress.
- `dn_memread`, out, 1: to `tiger_avalon` memread.
- `dn_memwrite`, out, 1: to `tiger_avalon` memwrite.
- `dn_memwritedata`, out, 32: to `tiger_avalon` memwritedata.
- `dn_mem8`, out, 1: to `tiger_avalon` mem8.
- `dn_mem16`, out, 1: to `tiger_avalon` mem16.
- `dn_stall`, in, 1: from `tiger_avalon` avalon_stall.
- `wbuf_empty`, out, 1: no buffered writes and no drain outstanding.
- `wbuf_count`, out, CNT_W: current occupancy.

## Operation

**Downstream acceptance.** A downstream request is accepted in any cycle where `dn_memread` or `dn_memwrite` is high and `dn_stall` is low.

**Entry format.** Each entry is {address[31:0], data[31:0], mem8, mem16}, 66 bits. Byte-lane alignment stays downstream.

**States:** S_IDLE, S_WRITE, S_READ.
- **S_IDLE**
  - Count > 0: go to S_WRITE.
  - Count = 0, `up_memread` high and `up_memwrite` low: read passthrough. `dn_*` are driven combinationally from `up_*`, and `up_stall = dn_stall`. On acceptance, go to S_READ.
- **S_WRITE**
  - `dn_memwrite = 1`; `dn_*` are driven from the FIFO head.
  - On acceptance, pop the head.
  - If count becomes 0, return to S_IDLE; otherwise stay and present the next entry the following cycle.
- **S_READ**
  - Passthrough is held and `up_stall = dn_stall`.
  - Return to S_IDLE in the first cycle `dn_stall` is low.
  - No enqueue is possible here, because the processor is stalled.

**Upstream stores**
- Any state, `up_memwrite` high, count < DEPTH: enqueue this cycle and drive `up_stall = 0`.
- Count = DEPTH: `up_stall = 1`. Full is judged on the registered count; a pop in the same cycle does not admit the store.

**Upstream loads.** With count > 0 or state ≠ S_IDLE: `up_stall = 1` and `dn_memread = 0` until the drain completes.

**Boundary cases**
- `up_memread` and `up_memwrite` both high is illegal. The block treats it as a write and ignores the read.
- Simultaneous enqueue and pop: count is unchanged and pointers wrap modulo DEPTH.
- Enqueue into an empty buffer is presented downstream the next cycle, never the same cycle.
- Reset mid-operation discards all buffered writes.

**Outputs while `reset` is high**
- `dn_memread = dn_memwrite = 0`.
- `up_stall = 0`.
- `wbuf_count = 0`.
- `wbuf_empty = 1`.
- `dn_memaddress`, `dn_memwritedata`, `dn_mem8` and `dn_mem16` are 0.

`wbuf_empty` is high exactly when count = 0 and state = S_IDLE.

## Timing

- Store: zero stall cycles when not full. `dn_memwrite` rises no earlier than 1 cycle after enqueue.
- Back-to-back drain: the next head is presented the cycle after acceptance; `tiger_avalon` stall pacing governs throughput.
- Load with an empty buffer: zero added cycles, fully combinational path from `up_*` to `dn_*`.
- Load behind N buffered writes: `up_memread` reaches downstream in the cycle after the last write's acceptance, while state = S_IDLE.
- FIFO storage, pointers, count and state are registered. Only the output muxes and `up_stall` are combinational.

## Structure

- Package `tiger_mem_pkg`:
  - state encodings (S_IDLE=0, S_WRITE=1, S_READ=2);
  - entry field widths and offsets;
  - the ENTRY_W=66 constant.
- Sub-module `tiger_wbuf_fifo`: synchronous FIFO, DEPTH×ENTRY_W, with push, pop, head, count, full and empty. The top level holds the FSM and the muxes.

## Test plan

- **Single store.** Write 0xDEADBEEF to 0x0000_1004 (word) at an idle buffer. Expect `up_stall = 0`, `wbuf_count = 1`, then `dn_memwrite` high the next cycle with the same address and data, then `wbuf_empty = 1` after acceptance.
- **Fill to full.** With `dn_stall` held high, issue 5 stores into DEPTH=4. Expect 4 enqueued and `up_stall = 1` on the 5th. Release `dn_stall` and expect 5 downstream writes in order with identical payloads.
- **Load after stores.** Issue 2 stores (mem8 to 0x3, mem16 to 0x6), then a load to 0x10. Expect `dn_memread` low until the second write is accepted, then 0x10 passthrough with `up_stall` mirroring `dn_stall`.
- **Wrap-around.** Run 12 alternating store/drain cycles so the pointers wrap 3 times. Expect ordering and data intact and count never above 4.
- **Load on empty buffer.** Issue a load to 0x20. Expect `dn_memread` high the same cycle and no added latency.
- **Reset mid-drain.** With 3 entries queued, assert `reset` mid-drain. Expect `dn_memwrite = 0` immediately, count 0, and no stale writes after release.
